// File: rtl/reset_sequencer.sv
// Board reset sequencer: debounced button, software request and power-on reset
// feed a hold timer that releases NUM_OUTS active-low domain resets in order.
module reset_sequencer #(
  parameter int NUM_OUTS        = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGGER_CYCLES  = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit BUT_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fpga_but1,
  input  logic                sw_req,
  output logic [NUM_OUTS-1:0] o_rstn,
  output logic                o_busy,
  output logic [1:0]          o_cause
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int MAX_CYC = (MAX_HS > DEBOUNCE_CYCLES) ? MAX_HS : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int KW      = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

  localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] STAG_LIM  = CW'(STAGGER_CYCLES);
  localparam logic [CW-1:0] DEB_LIM   = CW'(DEBOUNCE_CYCLES);
  localparam logic [KW-1:0] LAST_SLOT = KW'(NUM_OUTS - 1);
  localparam bit            SINGLE    = (NUM_OUTS == 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BUT = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_RELEASE  = 2'd1,
    ST_RUN      = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;

  // Button path works in "pressed = 1" polarity so reset value 0 means released.
  logic          but_pressed_raw;
  logic          sync1_reg, sync2_reg;
  logic          deb_reg;
  logic [CW-1:0] deb_cnt_reg;
  logic [CW-1:0] deb_cnt_inc;
  logic          deb_toggle;
  logic          press_event;
  logic          release_event;

  assign but_pressed_raw = BUT_ACTIVE_LOW ? ~fpga_but1 : fpga_but1;
  assign deb_cnt_inc     = deb_cnt_reg + CW'(1);
  assign deb_toggle      = (sync2_reg != deb_reg) && (deb_cnt_inc == DEB_LIM);
  assign press_event     = deb_toggle && !deb_reg;
  assign release_event   = deb_toggle && deb_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      deb_reg     <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg <= but_pressed_raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != deb_reg) begin
        if (deb_toggle) begin
          deb_reg     <= ~deb_reg;
          deb_cnt_reg <= '0;
        end else begin
          deb_cnt_reg <= deb_cnt_inc;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  state_t                state_reg, state_next;
  logic [CW-1:0]         cnt_reg, cnt_next, cnt_inc;
  logic [KW-1:0]         slot_reg, slot_next;
  logic [NUM_OUTS-1:0]   rstn_reg, rstn_next;
  logic [NUM_OUTS-1:0]   slot_mask;
  logic                  busy_reg, busy_next;
  logic [1:0]            cause_reg, cause_next;

  assign cnt_inc = cnt_reg + CW'(1);

  for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_slot_mask
    assign slot_mask[gi] = (slot_reg == KW'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_HOLD;
      cnt_reg   <= '0;
      slot_reg  <= '0;
      rstn_reg  <= '0;
      busy_reg  <= 1'b1;
      cause_reg <= CAUSE_POR;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      slot_reg  <= slot_next;
      rstn_reg  <= rstn_next;
      busy_reg  <= busy_next;
      cause_reg <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    slot_next  = slot_reg;
    rstn_next  = rstn_reg;
    busy_next  = busy_reg;
    cause_next = cause_reg;
    case (state_reg)
      ST_HOLD, ST_RELEASE: begin
        // Button beats software request when both arrive on the same edge.
        if (press_event) begin
          rstn_next  = '0;
          busy_next  = 1'b1;
          cause_next = CAUSE_BUT;
          cnt_next   = '0;
          state_next = ST_WAIT_REL;
        end else if (sw_req) begin
          rstn_next  = '0;
          busy_next  = 1'b1;
          cause_next = CAUSE_SW;
          cnt_next   = '0;
          state_next = ST_HOLD;
        end else if (state_reg == ST_HOLD) begin
          if (cnt_inc == HOLD_LIM) begin
            rstn_next[0] = 1'b1;
            cnt_next     = '0;
            slot_next    = KW'(1);
            if (SINGLE) begin
              busy_next  = 1'b0;
              state_next = ST_RUN;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end else begin
          if (cnt_inc == STAG_LIM) begin
            rstn_next = rstn_reg | slot_mask;
            cnt_next  = '0;
            if (slot_reg == LAST_SLOT) begin
              busy_next  = 1'b0;
              state_next = ST_RUN;
            end else begin
              slot_next = slot_reg + KW'(1);
            end
          end else begin
            cnt_next = cnt_inc;
          end
        end
      end
      ST_RUN: begin
        if (press_event) begin
          rstn_next  = '0;
          busy_next  = 1'b1;
          cause_next = CAUSE_BUT;
          state_next = ST_WAIT_REL;
        end else if (sw_req) begin
          rstn_next  = '0;
          busy_next  = 1'b1;
          cause_next = CAUSE_SW;
          cnt_next   = '0;
          state_next = ST_HOLD;
        end
      end
      ST_WAIT_REL: begin
        if (release_event) begin
          cnt_next   = '0;
          state_next = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_HOLD;
      end
    endcase
  end

  assign o_rstn  = rstn_reg;
  assign o_busy  = busy_reg;
  assign o_cause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomised bench for reset_sequencer against a timeline model that derives
// each output from "edges since the sequence started" and a button sample history.
module tb_reset_sequencer;

  localparam int N = 3;
  localparam int H = 16;
  localparam int S = 4;
  localparam int D = 8;

  localparam int PH_SEQ  = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_WAIT = 2;

  logic         clk;
  logic         reset;
  logic         fpga_but1;
  logic         sw_req;
  logic [N-1:0] o_rstn;
  logic         o_busy;
  logic [1:0]   o_cause;

  reset_sequencer #(
    .NUM_OUTS(N),
    .HOLD_CYCLES(H),
    .STAGGER_CYCLES(S),
    .DEBOUNCE_CYCLES(D),
    .BUT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fpga_but1(fpga_but1),
    .sw_req(sw_req),
    .o_rstn(o_rstn),
    .o_busy(o_busy),
    .o_cause(o_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: phase, edges since the sequence (re)started, cause, debounced level.
  int       m_phase;
  int       m_t;
  logic [1:0] m_cause;
  bit       m_deb;
  bit       hist [D+2];   // hist[0] = pressed level sampled at the latest edge

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_SEQ;
    m_t     = 0;
    m_cause = 2'b00;
    m_deb   = 1'b0;
    for (int i = 0; i < D + 2; i++) hist[i] = 1'b0;
  endtask

  task automatic model_edge(input bit pressed, input bit sw);
    bit toggle;
    bit press_ev;
    bit rel_ev;
    // Debounce sees samples two edges late; toggle when the last D all disagree.
    toggle = 1'b1;
    for (int i = 1; i <= D; i++) if (hist[i] == m_deb) toggle = 1'b0;
    press_ev = toggle && !m_deb;
    rel_ev   = toggle && m_deb;
    if (toggle) m_deb = !m_deb;
    for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = pressed;
    case (m_phase)
      PH_SEQ: begin
        if (press_ev) begin
          m_phase = PH_WAIT;
          m_cause = 2'b01;
        end else if (sw) begin
          m_t     = 0;
          m_cause = 2'b10;
        end else begin
          m_t++;
          if (m_t >= H + (N - 1) * S) m_phase = PH_RUN;
        end
      end
      PH_RUN: begin
        if (press_ev) begin
          m_phase = PH_WAIT;
          m_cause = 2'b01;
        end else if (sw) begin
          m_phase = PH_SEQ;
          m_t     = 0;
          m_cause = 2'b10;
        end
      end
      default: begin
        if (rel_ev) begin
          m_phase = PH_SEQ;
          m_t     = 0;
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] exp_rstn;
    exp_rstn = '0;
    if (m_phase == PH_RUN) exp_rstn = '1;
    else if (m_phase == PH_SEQ)
      for (int k = 0; k < N; k++) exp_rstn[k] = (m_t >= H + k * S);
    check_val({tag, "_rstn"}, 32'(o_rstn), 32'(exp_rstn));
    check_val({tag, "_busy"}, 32'(o_busy), 32'(m_phase != PH_RUN));
    check_val({tag, "_cause"}, 32'(o_cause), 32'(m_cause));
  endtask

  // One clock: drive at the negedge, advance the model at the posedge, check at the next negedge.
  task automatic step(input bit but, input bit sw);
    fpga_but1 = but;
    sw_req    = sw;
    @(posedge clk);
    model_edge(!but, sw);
    @(negedge clk);
    check_outputs("seq");
  endtask

  task automatic hold_in(input int len, input bit but, input bit sw);
    for (int i = 0; i < len; i++) step(but, sw);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1 model_reset();
    check_outputs("areset");
    @(negedge clk);
    check_outputs("areset_hold");
    reset = 1'b1;
  endtask

  initial begin
    int sel;
    int len;
    reset     = 1'b0;
    fpga_but1 = 1'b1;
    sw_req    = 1'b0;
    model_reset();
    repeat (5) begin
      @(negedge clk);
      check_outputs("por");
    end
    reset = 1'b1;
    $display("[TB] txn power-on");
    hold_in(30, 1'b1, 1'b0);
    $display("[TB] txn glitch 7");
    hold_in(7, 1'b0, 1'b0);
    hold_in(12, 1'b1, 1'b0);
    $display("[TB] txn press 50 then release");
    hold_in(50, 1'b0, 1'b0);
    hold_in(40, 1'b1, 1'b0);
    $display("[TB] txn sw pulse in run");
    step(1'b1, 1'b1);
    hold_in(21, 1'b1, 1'b0);
    $display("[TB] txn sw pulse at 011");
    step(1'b1, 1'b1);
    hold_in(30, 1'b1, 1'b0);
    $display("[TB] txn press with sw held");
    hold_in(15, 1'b0, 1'b1);
    hold_in(40, 1'b1, 1'b0);
    $display("[TB] txn mid-sequence reset");
    pulse_reset();
    hold_in(17, 1'b1, 1'b0);
    pulse_reset();
    hold_in(30, 1'b1, 1'b0);

    for (int seg = 0; seg < 40; seg++) begin
      sel = $urandom_range(0, 6);
      $display("[TB] txn random seg %0d type %0d", seg, sel);
      case (sel)
        0: begin
          len = $urandom_range(10, 60);
          for (int i = 0; i < len; i++) step(1'b1, ($urandom_range(0, 29) == 0));
        end
        1: begin
          hold_in($urandom_range(1, D - 1), 1'b0, 1'b0);
          hold_in($urandom_range(1, 6), 1'b1, 1'b0);
        end
        2: begin
          len = $urandom_range(D + 1, 70);
          for (int i = 0; i < len; i++) step(1'b0, ($urandom_range(0, 9) == 0));
          hold_in($urandom_range(D + 1, 40), 1'b1, 1'b0);
        end
        3: begin
          hold_in($urandom_range(D + 5, 40), 1'b0, 1'b1);
          hold_in($urandom_range(D + 1, 30), 1'b1, 1'b0);
        end
        4: hold_in($urandom_range(1, 10), 1'b1, 1'b1);
        5: begin
          pulse_reset();
          hold_in($urandom_range(5, 30), 1'b1, 1'b0);
        end
        default: begin
          len = $urandom_range(5, 30);
          for (int i = 0; i < len; i++) step(1'($urandom_range(0, 1)), 1'b0);
        end
      endcase
    end
    hold_in(40, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised successor to the single-output board reset block.
- Takes the FPGA-configured signal as its asynchronous reset and the user button as a second reset source.
- Debounces the button, holds reset for a programmable time, then releases NUM_OUTS active-low domain resets in a staggered order, one per release slot (e.g. clock generator first, then VIC, then RAM/CPU).
- Also accepts a software reset request and reports the cause of the last reset.

Parameters:
- NUM_OUTS, 3: number of sequenced reset outputs; legal range 1..8.
- HOLD_CYCLES, 16: clk edges all outputs stay asserted before the first release; must be >= 1.
- STAGGER_CYCLES, 4: clk edges between consecutive output releases; must be >= 1.
- DEBOUNCE_CYCLES, 8: consecutive synchronised samples at one level required to accept a button level change; must be >= 1.
- BUT_ACTIVE_LOW, 1: 1 = button pressed when fpga_but1 = 0; 0 = pressed when fpga_but1 = 1.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-low reset (driven from fpga_start).
- fpga_but1  input  1  raw asynchronous user button.
- sw_req  input  1  synchronous software reset request; single-cycle pulse; level is treated as repeated requests.
- o_rstn  output  NUM_OUTS  active-low domain resets; bit 0 released first.
- o_busy  output  1  high while any o_rstn bit is asserted (low).
- o_cause  output  2  cause of last reset entry: 00 power-on, 01 button, 10 software; 11 never driven.

Behaviour:
- Async reset (reset = 0):
  - o_rstn = all 0, o_busy = 1, o_cause = 00.
  - State = HOLD; counters = 0; synchroniser and debounce state = "released".
  - Takes effect immediately, including mid-sequence.
- Deassertion of reset is taken on clk; edge 1 is the first rising edge with reset = 1.
- Button path:
  - 2-flop synchroniser, then debounce counter.
  - The debounced level toggles when DEBOUNCE_CYCLES consecutive synchronised samples differ from the current debounced level; any agreeing sample clears the counter.
  - With raw pressed stable from before edge n, the press event occurs at edge n + 1 + DEBOUNCE_CYCLES.
- States:
  - HOLD:
    - Counter increments each edge.
    - At count == HOLD_CYCLES: o_rstn[0] <= 1, counter cleared, go RELEASE with slot index k = 1.
    - If NUM_OUTS == 1: go RUN and drop o_busy on that same edge.
  - RELEASE:
    - Counter increments each edge.
    - At count == STAGGER_CYCLES: o_rstn[k] <= 1, counter cleared, k++.
    - When k == NUM_OUTS-1 is released: o_busy <= 0 on the same edge, go RUN.
  - RUN:
    - Outputs all 1.
    - Press event: o_rstn <= 0, o_busy <= 1, o_cause <= 01, go WAIT_REL.
    - sw_req = 1: o_rstn <= 0, o_busy <= 1, o_cause <= 10, go HOLD with counter = 0.
  - WAIT_REL:
    - Outputs held asserted.
    - On debounced release event: go HOLD with counter = 0.
    - sw_req is ignored here; o_cause stays 01.
- Release timing from power-on: o_rstn[k] rises on edge HOLD_CYCLES + k*STAGGER_CYCLES; outputs are monotonic (bit k never high while bit k-1 low).
- Press event in HOLD or RELEASE:
  - All o_rstn <= 0, o_cause <= 01, go WAIT_REL.
  - The sequence restarts from scratch after release.
- sw_req in HOLD or RELEASE: all o_rstn <= 0, counter cleared, stay/return HOLD, o_cause <= 10.
- Simultaneous press event and sw_req: button wins (cause 01, WAIT_REL).
- Button held pressed through power-on: the press event after debounce moves to WAIT_REL; outputs never release until the button is debounced released.
- Counters are sized $clog2(max(HOLD_CYCLES, STAGGER_CYCLES, DEBOUNCE_CYCLES) + 1) bits and never wrap.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (NUM_OUTS = 3, HOLD_CYCLES = 16, STAGGER_CYCLES = 4, DEBOUNCE_CYCLES = 8, BUT_ACTIVE_LOW = 1):
- Power-on: reset low 5 cycles then high, button = 1 -> o_rstn 000 -> 001 at edge 16 -> 011 at edge 20 -> 111 at edge 24; o_busy falls at edge 24; o_cause = 00.
- Button glitch: fpga_but1 = 0 for 7 cycles while in RUN -> no change, o_rstn stays 111.
- Button press: fpga_but1 = 0 stable from before edge n in RUN -> o_rstn = 000, o_busy = 1, o_cause = 01 at edge n + 9.
  - Release after 50 cycles -> HOLD entered at the release-debounce event, then 001/011/111 at +16/+20/+24 edges.
- Software reset: sw_req pulse in RUN -> o_rstn 000 and o_cause = 10 next edge; o_rstn releases 16/20/24 edges after the pulse edge.
- Simultaneous events: sw_req while o_rstn = 011 -> all 0, hold restarts from 0; press event and sw_req on the same edge -> o_cause = 01, stays asserted until button released.
- Mid-sequence reset: reset low for 1 cycle at edge 18 -> o_rstn 000 asynchronously, o_cause = 00, full sequence restarts from edge 1 after deassertion.
